// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : button_debouncer
// Description : Synchronises and debounces an active-low push button and
//               emits press, release and optional auto-repeat strobes.
// Revision    : 1.0 - initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 120000,
    parameter bit REPEAT_EN       = 1'b0,
    parameter int REPEAT_DELAY    = 6000000,
    parameter int REPEAT_PERIOD   = 1200000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_n,
    output logic btn_level,
    output logic press_pulse,
    output logic release_pulse
);

    localparam int c_rep_max = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int c_db_w    = $clog2(DEBOUNCE_CYCLES);
    localparam int c_rep_w   = $clog2(c_rep_max);

    localparam logic [c_db_w-1:0]  c_db_last         = c_db_w'(DEBOUNCE_CYCLES - 1);
    localparam logic [c_db_w-1:0]  c_db_one          = c_db_w'(1);
    localparam logic [c_rep_w-1:0] c_rep_delay_last  = c_rep_w'(REPEAT_DELAY - 1);
    localparam logic [c_rep_w-1:0] c_rep_period_last = c_rep_w'(REPEAT_PERIOD - 1);
    localparam logic [c_rep_w-1:0] c_rep_one         = c_rep_w'(1);

    generate
        if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
            $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
        end
        if (REPEAT_DELAY < 2) begin : g_bad_repeat_delay
            $error("button_debouncer: REPEAT_DELAY must be at least 2");
        end
        if (REPEAT_PERIOD < 2) begin : g_bad_repeat_period
            $error("button_debouncer: REPEAT_PERIOD must be at least 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [c_db_w-1:0]    r_db_cnt;
    logic [c_rep_w-1:0]   r_rep_cnt;
    logic                 r_rep_first;
    logic                 r_btn_level;
    logic                 r_press_pulse;
    logic                 r_release_pulse;

    logic                 w_btn_sync;
    logic [c_rep_w-1:0]   w_rep_target;

    // Synchroniser idles at 1 (released) so a button held through reset is re-debounced.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync <= 2'b11;
        end else begin
            r_sync <= {r_sync[0], btn_n};
        end
    end

    assign w_btn_sync   = ~r_sync[1];
    assign w_rep_target = r_rep_first ? c_rep_delay_last : c_rep_period_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state         <= IDLE;
            r_db_cnt        <= '0;
            r_rep_cnt       <= '0;
            r_rep_first     <= 1'b1;
            r_btn_level     <= 1'b0;
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
        end else begin
            r_press_pulse   <= 1'b0;
            r_release_pulse <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_btn_sync) begin
                        r_state  <= PRESS_WAIT;
                        r_db_cnt <= '0;
                    end
                end
                PRESS_WAIT: begin
                    if (!w_btn_sync) begin
                        r_state <= IDLE;
                    end else if (r_db_cnt == c_db_last) begin
                        r_state       <= HELD;
                        r_db_cnt      <= '0;
                        r_rep_cnt     <= '0;
                        r_rep_first   <= 1'b1;
                        r_press_pulse <= 1'b1;
                        r_btn_level   <= 1'b1;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_db_one;
                    end
                end
                HELD: begin
                    if (!w_btn_sync) begin
                        r_state  <= RELEASE_WAIT;
                        r_db_cnt <= '0;
                    end else if (REPEAT_EN) begin
                        // Repeat counter only advances here, so a release glitch freezes it.
                        if (r_rep_cnt == w_rep_target) begin
                            r_rep_cnt     <= '0;
                            r_rep_first   <= 1'b0;
                            r_press_pulse <= 1'b1;
                        end else begin
                            r_rep_cnt <= r_rep_cnt + c_rep_one;
                        end
                    end
                end
                RELEASE_WAIT: begin
                    if (w_btn_sync) begin
                        r_state <= HELD;
                    end else if (r_db_cnt == c_db_last) begin
                        r_state         <= IDLE;
                        r_db_cnt        <= '0;
                        r_release_pulse <= 1'b1;
                        r_btn_level     <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + c_db_one;
                    end
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign btn_level     = r_btn_level;
    assign press_pulse   = r_press_pulse;
    assign release_pulse = r_release_pulse;

endmodule
`default_nettype wire

// File: tb/tb_button_debouncer.sv
`default_nettype none
// Bench for button_debouncer: two instances (repeat off / on) share the button
// and reset; outputs are compared as {btn_level, press_pulse, release_pulse}.
module tb_button_debouncer;

    localparam int c_db = 4;
    localparam int c_rd = 10;
    localparam int c_rp = 5;

    logic clk = 1'b0;
    logic rst;
    logic btn_n;
    logic lvl0, pr0, rl0;
    logic lvl1, pr1, rl1;

    int n_pass  = 0;
    int n_total = 0;

    typedef struct {
        logic       btn_n;
        logic [2:0] exp;
    } vec_t;

    vec_t vecs[$];

    always #5 clk = ~clk;

    button_debouncer #(
        .DEBOUNCE_CYCLES(c_db),
        .REPEAT_EN      (1'b0),
        .REPEAT_DELAY   (c_rd),
        .REPEAT_PERIOD  (c_rp)
    ) u_dut0 (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .btn_level    (lvl0),
        .press_pulse  (pr0),
        .release_pulse(rl0)
    );

    button_debouncer #(
        .DEBOUNCE_CYCLES(c_db),
        .REPEAT_EN      (1'b1),
        .REPEAT_DELAY   (c_rd),
        .REPEAT_PERIOD  (c_rp)
    ) u_dut1 (
        .clk          (clk),
        .rst          (rst),
        .btn_n        (btn_n),
        .btn_level    (lvl1),
        .press_pulse  (pr1),
        .release_pulse(rl1)
    );

    function automatic void add(input logic b, input logic [2:0] e, input int n);
        for (int i = 0; i < n; i++) vecs.push_back('{btn_n: b, exp: e});
    endfunction

    task automatic chk(input string name, input logic [2:0] act, input logic [2:0] exp,
                       input logic [2:0] mask);
        n_total++;
        if ((act & mask) === (exp & mask)) n_pass++;
        else $display("FAIL %s: got {level,press,release}=%b, expected %b (mask %b) at %0t",
                      name, act, exp, mask, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive one btn_n sample, advance one edge, check both instances.
    task automatic step(input string tag, input int e, input logic b,
                        input logic [2:0] e0, input logic [2:0] m0,
                        input logic [2:0] e1, input logic [2:0] m1);
        btn_n = b;
        tick();
        chk($sformatf("%s e%0d dut0", tag, e), {lvl0, pr0, rl0}, e0, m0);
        chk($sformatf("%s e%0d dut1", tag, e), {lvl1, pr1, rl1}, e1, m1);
    endtask

    // Release from a held state: release_pulse after the 7th high edge.
    task automatic release_seq(input string tag, input logic [2:0] m1);
        logic [2:0] e;
        for (int s = 1; s <= 8; s++) begin
            e = (s < 7) ? 3'b100 : ((s == 7) ? 3'b001 : 3'b000);
            step(tag, s, 1'b1, e, 3'b111, e, m1);
        end
    endtask

    initial begin
        logic [2:0] e0;
        logic [2:0] e1;

        // press bounce: 3 low samples then high -> nothing
        add(1'b0, 3'b000, 3);
        add(1'b1, 3'b000, 6);
        // clean press: pulse after edge 7, level held
        add(1'b0, 3'b000, 6);
        add(1'b0, 3'b110, 1);
        add(1'b0, 3'b100, 5);
        // clean release
        add(1'b1, 3'b100, 6);
        add(1'b1, 3'b001, 1);
        add(1'b1, 3'b000, 1);

        rst   = 1'b1;
        btn_n = 1'b1;
        tick();
        tick();
        chk("reset dut0", {lvl0, pr0, rl0}, 3'b000, 3'b111);
        chk("reset dut1", {lvl1, pr1, rl1}, 3'b000, 3'b111);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) tick();

        for (int i = 0; i < vecs.size(); i++) begin
            step("table", i, vecs[i].btn_n, vecs[i].exp, 3'b111, vecs[i].exp, 3'b111);
        end

        // release bounce: high 2, low 2, then steady high
        for (int e = 1; e <= 8; e++) begin
            e0 = (e < 7) ? 3'b000 : ((e == 7) ? 3'b110 : 3'b100);
            step("glitch_press", e, 1'b0, e0, 3'b111, e0, 3'b111);
        end
        step("glitch", 1, 1'b1, 3'b100, 3'b111, 3'b100, 3'b111);
        step("glitch", 2, 1'b1, 3'b100, 3'b111, 3'b100, 3'b111);
        step("glitch", 3, 1'b0, 3'b100, 3'b111, 3'b100, 3'b111);
        step("glitch", 4, 1'b0, 3'b100, 3'b111, 3'b100, 3'b111);
        release_seq("glitch_release", 3'b111);

        // auto-repeat over a 40-edge hold; press pulses checked through edge 40
        for (int e = 1; e <= 40; e++) begin
            e0 = (e < 7) ? 3'b000 : ((e == 7) ? 3'b110 : 3'b100);
            if (e < 7) e1 = 3'b000;
            else if (e == 7 || e == 17 || e == 22 || e == 27 || e == 32 || e == 37) e1 = 3'b110;
            else e1 = 3'b100;
            step("repeat", e, 1'b0, e0, 3'b111, e1, 3'b111);
        end
        release_seq("repeat_release", 3'b101);

        // repeat counter freezes across a release glitch and resumes
        for (int e = 1; e <= 26; e++) begin
            e0 = (e < 7) ? 3'b000 : ((e == 7) ? 3'b110 : 3'b100);
            if (e < 7) e1 = 3'b000;
            else if (e == 7 || e == 20 || e == 25) e1 = 3'b110;
            else e1 = 3'b100;
            step("resume", e, (e == 15 || e == 16), e0, 3'b111, e1, 3'b111);
        end
        release_seq("resume_release", 3'b111);

        // reset during PRESS_WAIT
        for (int e = 1; e <= 4; e++) step("rst_pw_pre", e, 1'b0, 3'b000, 3'b111, 3'b000, 3'b111);
        rst = 1'b1;
        #1;
        chk("rst_pw assert dut0", {lvl0, pr0, rl0}, 3'b000, 3'b111);
        chk("rst_pw assert dut1", {lvl1, pr1, rl1}, 3'b000, 3'b111);
        tick();
        tick();
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            e0 = (e < 7) ? 3'b000 : ((e == 7) ? 3'b110 : 3'b100);
            step("rst_pw_post", e, 1'b0, e0, 3'b111, e0, 3'b111);
        end

        // reset while HELD: level drops without a clock, held button re-debounced
        #2;
        rst = 1'b1;
        #1;
        chk("rst_held async dut0", {lvl0, pr0, rl0}, 3'b000, 3'b111);
        chk("rst_held async dut1", {lvl1, pr1, rl1}, 3'b000, 3'b111);
        @(negedge clk);
        chk("rst_held clocked dut0", {lvl0, pr0, rl0}, 3'b000, 3'b111);
        chk("rst_held clocked dut1", {lvl1, pr1, rl1}, 3'b000, 3'b111);
        rst = 1'b0;
        for (int e = 1; e <= 8; e++) begin
            e0 = (e < 7) ? 3'b000 : ((e == 7) ? 3'b110 : 3'b100);
            step("rst_held_post", e, 1'b0, e0, 3'b111, e0, 3'b111);
        end
        release_seq("rst_held_release", 3'b111);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire
